framebuffer_reader_unpack: RTL and testbench

Read-side counterpart of the framebuffer writer's pixel-strobe path. It accepts a span read command (pixel-aligned byte address and pixel count) and issues one beat-aligned memory read request. It then unpacks the returned wide memory beats into a pixel-per-cycle AXI-Stream, discarding leading and trailing pixels that fall outside the span. It sits between the memory read port and the display/readback path.

---
 rtl/framebuffer_pkg.sv | 25 ++
 rtl/framebuffer_reader_pixel_select.sv | 23 ++
 rtl/framebuffer_reader_unpack.sv | 155 +++++++++++++++
 tb/tb_framebuffer_reader_unpack.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_pkg.sv
// rtl/framebuffer_pkg.sv - shared framebuffer state encoding and geometry helpers
package framebuffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2
  } fb_state_e;

  function automatic int calc_ppb(input int data_w, input int pixel_w);
    return data_w / pixel_w;
  endfunction

  // Never narrower than one bit so a single-pixel beat still has an index port.
  function automatic int calc_idx_w(input int data_w, input int pixel_w);
    int ppb;
    ppb = data_w / pixel_w;
    return (ppb > 1) ? $clog2(ppb) : 1;
  endfunction

  function automatic int calc_beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/framebuffer_reader_pixel_select.sv
// rtl/framebuffer_reader_pixel_select.sv - selects one pixel lane out of a memory beat
module framebuffer_reader_pixel_select
  import framebuffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int PIXEL_WIDTH = 16,
  parameter int IDX_W       = calc_idx_w(DATA_WIDTH, PIXEL_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  word_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [PIXEL_WIDTH-1:0] pixel_o
);

  localparam int PPB = calc_ppb(DATA_WIDTH, PIXEL_WIDTH);

  always_comb begin
    pixel_o = '0;
    for (int i = 0; i < PPB; i++) begin
      if (idx_i == IDX_W'(i)) pixel_o = word_i[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

endmodule

// File: rtl/framebuffer_reader_unpack.sv
// rtl/framebuffer_reader_unpack.sv - span read command to beat request and pixel stream unpacker
module framebuffer_reader_unpack
  import framebuffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 20
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s_cmd_valid,
  output logic                   s_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  s_cmd_addr,
  input  logic [CNT_WIDTH-1:0]   s_cmd_pixels,
  output logic                   m_ar_valid,
  input  logic                   m_ar_ready,
  output logic [ADDR_WIDTH-1:0]  m_ar_addr,
  output logic [CNT_WIDTH-1:0]   m_ar_beats,
  input  logic                   s_r_valid,
  output logic                   s_r_ready,
  input  logic [DATA_WIDTH-1:0]  s_r_data,
  input  logic                   s_r_last,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast
);

  localparam int PPB        = calc_ppb(DATA_WIDTH, PIXEL_WIDTH);
  localparam int IDX_W      = calc_idx_w(DATA_WIDTH, PIXEL_WIDTH);
  localparam int BEAT_BYTES = calc_beat_bytes(DATA_WIDTH);
  localparam int BB_W       = $clog2(BEAT_BYTES);
  localparam int PIX_BYTES  = PIXEL_WIDTH / 8;
  localparam int SPAN_W     = CNT_WIDTH + 1;

  fb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [CNT_WIDTH-1:0]  ar_beats_q, ar_beats_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [IDX_W-1:0]      first_idx_q, first_idx_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  first_beat_q, first_beat_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic [BB_W-1:0]   cmd_offset;
  logic [IDX_W-1:0]  cmd_first_idx;
  logic [SPAN_W-1:0] cmd_span;
  logic [SPAN_W-1:0] cmd_beats;
  logic              pix_hs;
  logic              last_pix;
  logic              beat_done;
  logic              unused_sig;

  // Span length is widened by one bit so a leading offset cannot wrap the beat count.
  assign cmd_offset    = s_cmd_addr[BB_W-1:0];
  assign cmd_first_idx = IDX_W'(cmd_offset / BB_W'(PIX_BYTES));
  assign cmd_span      = SPAN_W'(cmd_first_idx) + {1'b0, s_cmd_pixels};
  assign cmd_beats     = (cmd_span + SPAN_W'(PPB - 1)) / SPAN_W'(PPB);

  assign pix_hs    = full_q && m_axis_tready;
  assign last_pix  = (remaining_q == CNT_WIDTH'(1));
  assign beat_done = (idx_q == IDX_W'(PPB - 1)) || last_pix;

  // Refill in the same cycle the held beat drains, keeping one pixel per cycle.
  assign s_r_ready = (state_q == ST_STREAM) && (!full_q || (pix_hs && beat_done && !last_pix));

  assign s_cmd_ready   = (state_q == ST_IDLE);
  assign m_ar_valid    = (state_q == ST_REQ);
  assign m_ar_addr     = ar_addr_q;
  assign m_ar_beats    = ar_beats_q;
  assign m_axis_tvalid = full_q;
  assign m_axis_tlast  = full_q && last_pix;
  assign unused_sig    = s_r_last ^ cmd_beats[CNT_WIDTH];

  framebuffer_reader_pixel_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .IDX_W      (IDX_W)
  ) u_pixel_select (
    .word_i (word_q),
    .idx_i  (idx_q),
    .pixel_o(m_axis_tdata)
  );

  always_comb begin
    state_d      = state_q;
    ar_addr_d    = ar_addr_q;
    ar_beats_d   = ar_beats_q;
    remaining_d  = remaining_q;
    first_idx_d  = first_idx_q;
    idx_d        = idx_q;
    first_beat_d = first_beat_q;
    full_d       = full_q;
    word_d       = word_q;
    case (state_q)
      ST_IDLE: begin
        if (s_cmd_valid && (s_cmd_pixels != '0)) begin
          ar_addr_d   = {s_cmd_addr[ADDR_WIDTH-1:BB_W], {BB_W{1'b0}}};
          ar_beats_d  = cmd_beats[CNT_WIDTH-1:0];
          remaining_d = s_cmd_pixels;
          first_idx_d = cmd_first_idx;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_ar_ready) begin
          first_beat_d = 1'b1;
          state_d      = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pix_hs) begin
          remaining_d = remaining_q - CNT_WIDTH'(1);
          idx_d       = idx_q + IDX_W'(1);
          if (beat_done) full_d = 1'b0;
          if (last_pix) state_d = ST_IDLE;
        end
        if (s_r_valid && s_r_ready) begin
          word_d       = s_r_data;
          idx_d        = first_beat_q ? first_idx_q : '0;
          first_beat_d = 1'b0;
          full_d       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ar_addr_q    <= '0;
      ar_beats_q   <= '0;
      remaining_q  <= '0;
      first_idx_q  <= '0;
      idx_q        <= '0;
      first_beat_q <= 1'b0;
      full_q       <= 1'b0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      ar_addr_q    <= ar_addr_d;
      ar_beats_q   <= ar_beats_d;
      remaining_q  <= remaining_d;
      first_idx_q  <= first_idx_d;
      idx_q        <= idx_d;
      first_beat_q <= first_beat_d;
      full_q       <= full_d;
      word_q       <= word_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_reader_unpack.sv
// tb/tb_framebuffer_reader_unpack.sv - scoreboard bench for the framebuffer span reader
module tb_framebuffer_reader_unpack;

  localparam int DW = 128;
  localparam int PW = 16;
  localparam int AW = 32;
  localparam int CW = 20;
  localparam int NPIX = DW / PW;
  localparam int BBYTES = DW / 8;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic [AW-1:0] s_cmd_addr = '0;
  logic [CW-1:0] s_cmd_pixels = '0;
  logic          m_ar_valid;
  logic          m_ar_ready = 1'b0;
  logic [AW-1:0] m_ar_addr;
  logic [CW-1:0] m_ar_beats;
  logic          s_r_valid = 1'b0;
  logic          s_r_ready;
  logic [DW-1:0] s_r_data = '0;
  logic          s_r_last = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  framebuffer_reader_unpack #(
    .DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_addr(s_cmd_addr), .s_cmd_pixels(s_cmd_pixels),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_beats(m_ar_beats),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_r_data(s_r_data), .s_r_last(s_r_last),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass = 0;
  int tready_pct = 100;
  int rvalid_pct = 100;
  int arready_pct = 100;
  logic [15:0] salt = 16'h0;

  logic [PW-1:0] exp_pix[$];
  logic          exp_last[$];
  logic [AW-1:0] exp_ar_addr[$];
  int            exp_ar_beats[$];
  logic [AW-1:0] beat_q[$];

  // Memory contents: every pixel-aligned byte address holds a value derived from that address.
  function automatic logic [PW-1:0] pix_at(input logic [AW-1:0] a, input logic [15:0] s);
    logic [31:0] h;
    h = (a >> 1) * 32'h0000_9E37;
    return h[15:0] ^ s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: accepts requests, returns exactly the requested beats.
  always @(negedge aclk) begin
    m_ar_ready = ($urandom_range(99) < arready_pct);
    s_r_valid  = (beat_q.size() > 0) && ($urandom_range(99) < rvalid_pct);
    s_r_last   = (beat_q.size() == 1);
    s_r_data   = '0;
    if (beat_q.size() > 0)
      for (int i = 0; i < NPIX; i++) s_r_data[i*PW +: PW] = pix_at(beat_q[0] + AW'(2 * i), salt);
    #1;
    if (!reset) begin
      if (m_ar_valid && m_ar_ready) begin
        if (exp_ar_addr.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          check("ar_addr", m_ar_addr, exp_ar_addr.pop_front());
          check("ar_beats", m_ar_beats, exp_ar_beats.pop_front());
        end
        for (int b = 0; b < int'(m_ar_beats); b++) beat_q.push_back(m_ar_addr + AW'(BBYTES * b));
      end
      if (s_r_valid && s_r_ready) void'(beat_q.pop_front());
    end
  end

  // Output monitor: pops the scoreboard on every pixel handshake.
  logic          stalled = 1'b0;
  logic [PW-1:0] held = '0;
  always @(negedge aclk) begin
    m_axis_tready = ($urandom_range(99) < tready_pct);
    #1;
    if (reset) stalled = 1'b0;
    else begin
      if (stalled) begin
        check("tvalid_held", m_axis_tvalid, 1);
        check("tdata_held", m_axis_tdata, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        stalled = 1'b0;
        if (exp_pix.size() == 0) check("pixel_unexpected", 1, 0);
        else begin
          check("tdata", m_axis_tdata, exp_pix.pop_front());
          check("tlast", m_axis_tlast, exp_last.pop_front());
        end
      end else if (m_axis_tvalid) begin
        stalled = 1'b1;
        held = m_axis_tdata;
      end else stalled = 1'b0;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] addr, input int pix);
    int waited;
    salt = 16'($urandom);
    @(negedge aclk);
    s_cmd_valid  = 1'b1;
    s_cmd_addr   = addr;
    s_cmd_pixels = CW'(pix);
    #1;
    waited = 0;
    while (!s_cmd_ready && waited < 50) begin
      @(negedge aclk);
      #1;
      waited++;
    end
    if (!s_cmd_ready) check("cmd_accept_timeout", 0, 1);
    else if (pix > 0) begin
      exp_ar_addr.push_back(addr - (addr % BBYTES));
      exp_ar_beats.push_back((int'((addr % BBYTES) / 2) + pix + NPIX - 1) / NPIX);
      for (int k = 0; k < pix; k++) begin
        exp_pix.push_back(pix_at(addr + AW'(2 * k), salt));
        exp_last.push_back(k == pix - 1);
      end
    end
    @(negedge aclk);
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while ((exp_pix.size() > 0 || exp_ar_addr.size() > 0 || beat_q.size() > 0) && c < budget) begin
      @(negedge aclk);
      #2;
      c++;
    end
    check("span_pixels_outstanding", exp_pix.size(), 0);
    @(negedge aclk);
    #2;
    check("idle_after_tlast", s_cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int first_c, last_c, vcnt;
    @(negedge aclk);
    #1;
    check("rst_cmd_ready", s_cmd_ready, 1);
    check("rst_ar_valid", m_ar_valid, 0);
    check("rst_r_ready", s_r_ready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_ar_addr", m_ar_addr, 0);
    check("rst_ar_beats", m_ar_beats, 0);
    check("rst_tdata", m_axis_tdata, 0);
    @(negedge aclk);
    #3 reset = 1'b0;

    send_cmd(32'h00, 8);
    wait_done(200);
    send_cmd(32'h0C, 5);
    wait_done(200);

    send_cmd(32'h10, 24);
    first_c = -1; last_c = -1; vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge aclk);
      #2;
      if (m_axis_tvalid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        vcnt++;
      end
    end
    check("burst_valid_count", vcnt, 24);
    check("burst_no_bubble", last_c - first_c + 1, 24);
    wait_done(200);

    tready_pct = 50; rvalid_pct = 40; arready_pct = 50;
    send_cmd(32'h24, 20);
    wait_done(1000);

    send_cmd(32'h40, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      #2;
      check("zero_no_ar", m_ar_valid, 0);
      check("zero_cmd_ready", s_cmd_ready, 1);
    end

    for (int t = 0; t < 12; t++) begin
      tready_pct  = $urandom_range(30, 100);
      rvalid_pct  = $urandom_range(30, 100);
      arready_pct = $urandom_range(30, 100);
      send_cmd(AW'($urandom_range(0, 255) * 2), $urandom_range(1, 40));
      wait_done(2000);
    end

    tready_pct = 100; rvalid_pct = 100; arready_pct = 100;
    send_cmd(32'h30, 40);
    for (int c = 0; c < 100 && exp_pix.size() > 30; c++) begin
      @(negedge aclk);
      #2;
    end
    #5;
    reset = 1'b1;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tlast", m_axis_tlast, 0);
    check("midrst_ar_valid", m_ar_valid, 0);
    check("midrst_r_ready", s_r_ready, 0);
    check("midrst_cmd_ready", s_cmd_ready, 1);
    exp_pix.delete();
    exp_last.delete();
    exp_ar_addr.delete();
    exp_ar_beats.delete();
    beat_q.delete();
    @(negedge aclk);
    @(negedge aclk);
    #3 reset = 1'b0;
    send_cmd(32'h06, 11);
    wait_done(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
